// File: rtl/clb_ff_bank_pkg.sv
// Shared types and constants for the configurable CLB flip-flop bank.
// Mode encoding is the 2-bit field decoded from the low end of the config chain.
package clb_ff_bank_pkg;

  localparam int MODE_BITS = 2;

  typedef logic [MODE_BITS-1:0] mode_t;

  localparam mode_t MODE_DFF = 2'b00;
  localparam mode_t MODE_CE  = 2'b01;
  localparam mode_t MODE_SR  = 2'b10;
  localparam mode_t MODE_TGL = 2'b11;

endpackage

// File: rtl/clb_ff_bank_ccff_chain.sv
// Serial configuration shift register; chain[0] sits next to the head.
// The tail is taken straight from the last register stage.
module clb_ff_bank_ccff_chain #(
  parameter int CHAIN_LEN = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 head,
  output logic                 tail,
  output logic [CHAIN_LEN-1:0] chain
);

  logic [CHAIN_LEN-1:0] chain_reg;
  logic [CHAIN_LEN-1:0] chain_next;

  assign chain_next = {chain_reg[CHAIN_LEN-2:0], head};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_reg <= '0;
    end else if (en) begin
      chain_reg <= chain_next;
    end
  end

  assign chain = chain_reg;
  assign tail  = chain_reg[CHAIN_LEN-1];

endmodule

// File: rtl/clb_ff_bank_cfg.sv
// Bank of WIDTH flip-flops whose mode and preset values come from a
// serially loaded configuration chain that daisy-chains between tiles.
module clb_ff_bank_cfg
  import clb_ff_bank_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [WIDTH-1:0] ff_D,
  input  logic             ff_ce,
  input  logic             ff_sr,
  input  logic             ccff_en,
  input  logic             ccff_head,
  output logic             ccff_tail,
  output logic [WIDTH-1:0] ff_Q
);

  localparam int CHAIN_LEN = WIDTH + MODE_BITS;

  logic [CHAIN_LEN-1:0] chain;
  mode_t                mode;
  logic [WIDTH-1:0]     init;
  logic [WIDTH-1:0]     q_reg;
  logic [WIDTH-1:0]     q_next;

  clb_ff_bank_ccff_chain #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_chain (
    .clk   (clk),
    .reset (reset),
    .en    (ccff_en),
    .head  (ccff_head),
    .tail  (ccff_tail),
    .chain (chain)
  );

  // Live decode: a partially shifted configuration is what the bank obeys.
  assign mode = chain[MODE_BITS-1:0];
  assign init = chain[CHAIN_LEN-1:MODE_BITS];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bit_next;

      // Shifting freezes the data register; set outranks every mode function.
      always_comb begin
        bit_next = q_reg[gi];
        if (ccff_en) begin
          bit_next = q_reg[gi];
        end else if (set) begin
          bit_next = init[gi];
        end else begin
          case (mode)
            MODE_DFF: bit_next = ff_D[gi];
            MODE_CE:  if (ff_ce) bit_next = ff_D[gi];
            MODE_SR: begin
              if (ff_sr)      bit_next = init[gi];
              else if (ff_ce) bit_next = ff_D[gi];
            end
            MODE_TGL: if (ff_ce) bit_next = q_reg[gi] ^ ff_D[gi];
          endcase
        end
      end

      assign q_next[gi] = bit_next;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign ff_Q = q_reg;

endmodule

// File: tb/tb_clb_ff_bank_cfg.sv
// Randomised and directed bench for clb_ff_bank_cfg with a scoreboard
// fed by a behavioural model of the configuration word and register bank.
module tb_clb_ff_bank_cfg;

  localparam int W = 4;
  localparam int CL = W + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         set = 1'b0;
  logic [W-1:0] ff_D = '0;
  logic         ff_ce = 1'b0;
  logic         ff_sr = 1'b0;
  logic         ccff_en = 1'b0;
  logic         ccff_head = 1'b0;
  logic         ccff_tail;
  logic [W-1:0] ff_Q;

  clb_ff_bank_cfg #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .set       (set),
    .ff_D      (ff_D),
    .ff_ce     (ff_ce),
    .ff_sr     (ff_sr),
    .ccff_en   (ccff_en),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .ff_Q      (ff_Q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         tail;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   txn = 0;

  // Model state: configuration held as a plain integer word, data as a vector.
  int           m_cfg = 0;
  logic [W-1:0] m_q = '0;

  task automatic model_step(input logic en, input logic head, input logic st,
                            input logic ce, input logic sr, input logic [W-1:0] d);
    int           md;
    logic [W-1:0] iv;
    md = m_cfg % 4;
    iv = W'(m_cfg / 4);
    if (en) begin
      m_cfg = (m_cfg * 2 + int'(head)) % (1 << CL);
    end else if (st) begin
      m_q = iv;
    end else if (md == 0) begin
      m_q = d;
    end else if (md == 1) begin
      if (ce) m_q = d;
    end else if (md == 2) begin
      if (sr) m_q = iv;
      else if (ce) m_q = d;
    end else begin
      if (ce) m_q = m_q ^ d;
    end
  endtask

  function automatic logic m_tail();
    return logic'((m_cfg >> (CL - 1)) & 1);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one expected entry per clock edge driven by the stimulus.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        txn++;
        tests++;
        if (ff_Q !== e.q || ccff_tail !== e.tail) begin
          fails++;
          $display("[TB] FAIL sb txn %0d: got q=%b tail=%b, expected q=%b tail=%b",
                   txn, ff_Q, ccff_tail, e.q, e.tail);
        end else begin
          $display("[TB] txn %0d q=%b tail=%b ok", txn, ff_Q, ccff_tail);
        end
      end
    end
  end

  task automatic drive(input logic en, input logic head, input logic st,
                       input logic ce, input logic sr, input logic [W-1:0] d);
    @(negedge clk);
    ccff_en = en; ccff_head = head; set = st; ff_ce = ce; ff_sr = sr; ff_D = d;
    model_step(en, head, st, ce, sr, d);
    sb.push_back('{q: m_q, tail: m_tail()});
    @(posedge clk);
    #2;
  endtask

  task automatic load_cfg(input logic [CL-1:0] word);
    logic [CL-1:0] w;
    w = word;
    for (int i = CL - 1; i >= 0; i--) begin
      drive(1'b1, w[i], 1'b1, 1'(i % 2), 1'b1, W'($urandom));
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    m_q = '0;
    m_cfg = 0;
    #1;
    chk("async_rst_q", ff_Q, '0);
    chk("async_rst_tail", {{(W-1){1'b0}}, ccff_tail}, '0);
    ccff_en = 1'b0; ccff_head = 1'b0; set = 1'b0; ff_ce = 1'b0; ff_sr = 1'b0; ff_D = '0;
    @(posedge clk);
    #2;
    chk("rst_hold_q", ff_Q, '0);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [CL-1:0] pat;
    logic [W-1:0]  d;
    logic [W-1:0]  q_before;

    // Power-up reset
    repeat (2) @(posedge clk);
    #2;
    chk("por_q", ff_Q, '0);
    chk("por_tail", {{(W-1){1'b0}}, ccff_tail}, '0);
    @(negedge clk);
    #1;
    reset = 1'b1;

    // 1: async reset mid-operation, then plain DFF passthrough
    drive(0, 0, 0, 0, 0, 4'b1111);
    chk("t1_pre", ff_Q, 4'b1111);
    async_reset();
    drive(0, 0, 0, 0, 0, 4'b1010);
    chk("t1_dff", ff_Q, 4'b1010);

    // 2: chain load freezes ff_Q, set loads INIT, then tail replays the word
    pat = 6'b1011_01;
    load_cfg(pat);
    chk("t2_hold", ff_Q, 4'b1010);
    drive(0, 0, 1, 0, 0, 4'b0000);
    chk("t2_set", ff_Q, 4'b1011);
    chk("t2_tail0", {{(W-1){1'b0}}, ccff_tail}, {{(W-1){1'b0}}, pat[CL-1]});
    for (int k = 1; k < CL; k++) begin
      drive(1, 0, 0, 0, 0, W'($urandom));
      chk($sformatf("t2_tail%0d", k), {{(W-1){1'b0}}, ccff_tail},
          {{(W-1){1'b0}}, pat[CL-1-k]});
    end
    drive(1, 0, 0, 0, 0, '0);

    // 3: enabled DFF
    load_cfg(6'b0000_01);
    drive(0, 0, 0, 0, 0, 4'b0110);
    chk("t3_hold", ff_Q, 4'b1011);
    drive(0, 0, 0, 1, 0, 4'b0110);
    chk("t3_ce", ff_Q, 4'b0110);

    // 4: sync reload beats clock enable
    load_cfg(6'b1001_10);
    drive(0, 0, 0, 1, 0, 4'b1111);
    chk("t4_ce", ff_Q, 4'b1111);
    drive(0, 0, 0, 1, 1, 4'b0110);
    chk("t4_sr", ff_Q, 4'b1001);

    // 5: toggle mode with a hold cycle in between
    load_cfg(6'b0000_11);
    drive(0, 0, 1, 0, 0, 4'b1111);
    chk("t5_clr", ff_Q, 4'b0000);
    drive(0, 0, 0, 1, 0, 4'b0011);
    chk("t5_tg1", ff_Q, 4'b0011);
    drive(0, 0, 0, 0, 0, 4'b0011);
    chk("t5_hold", ff_Q, 4'b0011);
    drive(0, 0, 0, 1, 0, 4'b0011);
    chk("t5_tg2", ff_Q, 4'b0000);
    drive(0, 0, 0, 1, 0, 4'b0011);
    chk("t5_tg3", ff_Q, 4'b0011);

    // 6: shift outranks set; set alone then loads the new INIT (0001)
    drive(1, 1, 1, 1, 1, 4'b1100);
    chk("t6_shift_hold", ff_Q, 4'b0011);
    drive(0, 0, 1, 1, 1, 4'b1100);
    chk("t6_set", ff_Q, 4'b0001);

    // Reset during a partial shift discards the configuration
    drive(1, 1, 0, 0, 0, '0);
    drive(1, 1, 0, 0, 0, '0);
    async_reset();
    d = W'($urandom);
    drive(0, 0, 0, 0, 1, d);
    chk("rst_mode_dff", ff_Q, d);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 7) == 0,
            1'($urandom), $urandom_range(0, 3) == 0, W'($urandom));
    end

    // A held-down shift leaves the register untouched for a whole chain length
    q_before = m_q;
    for (int k = 0; k < CL; k++) drive(1, 1'($urandom), 1, 1, 1, W'($urandom));
    chk("final_shift_hold", ff_Q, q_before);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clb_ff_bank_cfg.md
Name: clb_ff_bank_cfg

Overview:
- Parametrised successor to the single-bit CLB flip-flop primitive: a bank of WIDTH flip-flops sharing one clock, one active-low asynchronous reset and a global preset.
- Operating mode and per-bit preset values are held in an on-block configuration chain, loaded serially through a ccff head/tail port pair.
- Sits in the logical tile beside the LUT outputs and registers their results. The chain daisy-chains with the other tiles' ccff chains.

Parameters:
- WIDTH, 4, number of flip-flops in the bank (1..32).
- CHAIN_LEN, WIDTH+2, configuration chain length. Derived; not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state.
- set  input  1  global preset, synchronous, active-high; loads INIT into ff_Q.
- ff_D  input  WIDTH  data inputs.
- ff_ce  input  1  clock enable, honoured in modes 01/10/11.
- ff_sr  input  1  synchronous reload-to-INIT, mode 10 only.
- ccff_en  input  1  configuration shift enable.
- ccff_head  input  1  serial configuration input.
- ccff_tail  output  1  serial configuration output, equal to chain[CHAIN_LEN-1].
- ff_Q  output  WIDTH  registered outputs.

Behaviour:
- Reset (reset=0, asynchronous): ff_Q=0, chain=0 (so MODE=00 and INIT=0), ccff_tail=0. The block holds these values until the first rising clk edge after reset deasserts. Asserting reset mid-shift discards the partial configuration.
- Chain layout:
  - chain[0] is nearest the head.
  - MODE = {chain[1], chain[0]}.
  - INIT[i] = chain[2+i].
  - Shift order: the first bit shifted in ends at INIT[WIDTH-1]; the last bit shifted in is MODE[0].
- Priority per rising edge: ccff_en > set > mode function.
- ccff_en=1:
  - Shift: chain[0]<=ccff_head, chain[k]<=chain[k-1].
  - ff_Q holds; set, ff_sr and ff_ce are ignored.
  - MODE and INIT are live decodes of chain, so partial configurations take effect as soon as ccff_en drops.
- ccff_en=0, set=1: ff_Q<=INIT, regardless of MODE or ff_ce.
- ccff_en=0, set=0, by MODE:
  - 00 plain DFF: ff_Q<=ff_D; ff_ce and ff_sr are ignored.
  - 01 enabled DFF: if ff_ce then ff_Q<=ff_D, else hold.
  - 10 sync-reload DFF: if ff_sr then ff_Q<=INIT, else if ff_ce then ff_Q<=ff_D, else hold. ff_sr beats ff_ce.
  - 11 toggle: if ff_ce then ff_Q<=ff_Q XOR ff_D (bitwise), else hold.
- Latency:
  - Data path: one cycle.
  - Chain: CHAIN_LEN cycles from head to tail.
  - A bit shifted in appears at ccff_tail after CHAIN_LEN edges.
- ccff_tail is a direct register output with no combinational path from ccff_head.
- No X propagation: every state bit has a defined reset value.

Decomposition:
- Shared package clb_ff_bank_pkg holds:
  - a 2-bit mode typedef and constants MODE_DFF=2'b00, MODE_CE=2'b01, MODE_SR=2'b10, MODE_TGL=2'b11;
  - constant MODE_BITS=2.
- One sub-module, clb_ff_bank_ccff_chain:
  - a parametrised CHAIN_LEN shift register with clk/reset/en/head/tail;
  - exposes parallel chain contents for decode.
- The top level contains the mode decode and the WIDTH-bit data register.

Test Plan (WIDTH=4, CHAIN_LEN=6):
1. Reset check: assert reset mid-operation with ff_Q=4'b1111 -> ff_Q=0 and ccff_tail=0 immediately, without waiting for a clk edge; after release, MODE=00 and ff_D=4'b1010 gives ff_Q=4'b1010 the next cycle.
2. Chain load and passthrough: shift 6'b1011_01 (INIT=1011, MODE=01) MSB-first with ccff_en=1 while ff_D toggles -> ff_Q unchanged during the shift. Then set=1 -> ff_Q=4'b1011. Six further shifts of zeros -> ccff_tail emits 1,0,1,1,0,1.
3. MODE=01: ff_ce=0 with ff_D=4'b0110 -> ff_Q holds; ff_ce=1 -> ff_Q=4'b0110 one cycle later.
4. MODE=10, INIT=4'b1001, ff_sr=1 and ff_ce=1 with ff_D=4'b0110 in the same cycle -> ff_Q=4'b1001 (ff_sr wins).
5. MODE=11, ff_Q=4'b0000: three cycles with ff_ce=1 and ff_D=4'b0011 -> 0011, 0000, 0011. A ff_ce=0 cycle between them -> hold.
6. Simultaneous ccff_en=1 and set=1 -> chain shifts and ff_Q holds. The same cycle with ccff_en=0 -> ff_Q=INIT.
